// File: rtl/ps2_codes_pkg.sv
// Shared PS/2 set-2 scan codes, ASCII constants and decoder state encoding
// for the keyboard front-end blocks.
package ps2_codes_pkg;

  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam logic [7:0] ASCII_NUL     = 8'h00;
  localparam logic [7:0] ASCII_BS      = 8'h08;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_BREAK     = 2'd1;
  localparam logic [1:0] ST_EXT       = 2'd2;
  localparam logic [1:0] ST_EXT_BREAK = 2'd3;

  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational set-2 scan code to ASCII translation for printable keys,
// digits, space, enter and backspace.
module ps2_ascii_lut
  import ps2_codes_pkg::*;
(
  input  logic [7:0] i_scan,
  input  logic       i_shift,
  output logic [7:0] o_ascii,
  output logic       o_hit
);

  logic       w_is_letter;
  logic [4:0] w_letter_idx;

  always_comb begin
    w_is_letter  = 1'b1;
    w_letter_idx = '0;
    case (i_scan)
      8'h1C: w_letter_idx = 5'd0;
      8'h32: w_letter_idx = 5'd1;
      8'h21: w_letter_idx = 5'd2;
      8'h23: w_letter_idx = 5'd3;
      8'h24: w_letter_idx = 5'd4;
      8'h2B: w_letter_idx = 5'd5;
      8'h34: w_letter_idx = 5'd6;
      8'h33: w_letter_idx = 5'd7;
      8'h43: w_letter_idx = 5'd8;
      8'h3B: w_letter_idx = 5'd9;
      8'h42: w_letter_idx = 5'd10;
      8'h4B: w_letter_idx = 5'd11;
      8'h3A: w_letter_idx = 5'd12;
      8'h31: w_letter_idx = 5'd13;
      8'h44: w_letter_idx = 5'd14;
      8'h4D: w_letter_idx = 5'd15;
      8'h15: w_letter_idx = 5'd16;
      8'h2D: w_letter_idx = 5'd17;
      8'h1B: w_letter_idx = 5'd18;
      8'h2C: w_letter_idx = 5'd19;
      8'h3C: w_letter_idx = 5'd20;
      8'h2A: w_letter_idx = 5'd21;
      8'h1D: w_letter_idx = 5'd22;
      8'h22: w_letter_idx = 5'd23;
      8'h35: w_letter_idx = 5'd24;
      8'h1A: w_letter_idx = 5'd25;
      default: w_is_letter = 1'b0;
    endcase
  end

  always_comb begin
    o_ascii = ASCII_NUL;
    o_hit   = 1'b1;
    if (w_is_letter) begin
      o_ascii = (i_shift ? ASCII_UPPER_A : ASCII_LOWER_A) + {3'b000, w_letter_idx};
    end else begin
      case (i_scan)
        8'h45:     o_ascii = ASCII_ZERO + 8'd0;
        8'h16:     o_ascii = ASCII_ZERO + 8'd1;
        8'h1E:     o_ascii = ASCII_ZERO + 8'd2;
        8'h26:     o_ascii = ASCII_ZERO + 8'd3;
        8'h25:     o_ascii = ASCII_ZERO + 8'd4;
        8'h2E:     o_ascii = ASCII_ZERO + 8'd5;
        8'h36:     o_ascii = ASCII_ZERO + 8'd6;
        8'h3D:     o_ascii = ASCII_ZERO + 8'd7;
        8'h3E:     o_ascii = ASCII_ZERO + 8'd8;
        8'h46:     o_ascii = ASCII_ZERO + 8'd9;
        SC_SPACE:  o_ascii = ASCII_SPACE;
        SC_ENTER:  o_ascii = ASCII_CR;
        SC_BKSP:   o_ascii = ASCII_BS;
        default:   o_hit   = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_ascii_fifo.sv
// PS/2 scan-code decoder (make/break/extended, shift) feeding a small ASCII
// character FIFO drained with a valid/ready handshake.
module ps2_ascii_fifo
  import ps2_codes_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [7:0]        ps2_key_data,
  input  logic              ps2_key_pressed,
  input  logic              clear,
  output logic [7:0]        out_ascii,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        r_state;
  logic              r_shift;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic [7:0]        r_mem [DEPTH];

  logic [7:0] w_lut_ascii;
  logic       w_lut_hit;
  logic       w_valid;
  logic       w_full;
  logic       w_pop;
  logic       w_push_req;
  logic       w_push;
  logic       w_drop;

  ps2_ascii_lut u_lut (
    .i_scan  (ps2_key_data),
    .i_shift (r_shift),
    .o_ascii (w_lut_ascii),
    .o_hit   (w_lut_hit)
  );

  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == FULL_COUNT);
  assign w_pop      = w_valid & out_ready;
  assign w_push_req = ps2_key_pressed & (r_state == ST_IDLE) & w_lut_hit;
  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      r_state    <= ST_IDLE;
      r_shift    <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (ps2_key_pressed) begin
        case (r_state)
          ST_IDLE: begin
            if (ps2_key_data == SC_F0)
              r_state <= ST_BREAK;
            else if (ps2_key_data == SC_E0)
              r_state <= ST_EXT;
            else if (is_shift_code(ps2_key_data))
              r_shift <= 1'b1;
          end
          ST_BREAK: begin
            if (is_shift_code(ps2_key_data))
              r_shift <= 1'b0;
            r_state <= ST_IDLE;
          end
          ST_EXT:  r_state <= (ps2_key_data == SC_F0) ? ST_EXT_BREAK : ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (resetn && !clear && w_push)
      r_mem[r_wr_ptr] <= w_lut_ascii;
  end

  assign out_valid = w_valid;
  assign out_ascii = w_valid ? r_mem[r_rd_ptr] : ASCII_NUL;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_ascii_fifo.sv
// Directed self-checking bench for ps2_ascii_fifo: decoding, shift handling,
// FIFO occupancy, overflow, clear and reset-in-prefix behaviour.
module tb_ps2_ascii_fifo;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       clear;
  logic [7:0] out_ascii;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       overflow;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ps2_ascii_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .clear           (clear),
    .out_ascii       (out_ascii),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .count           (count),
    .overflow        (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe one byte; returns at the falling edge after it was sampled.
  task automatic send(input logic [7:0] b);
    @(negedge clock);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  initial begin
    resetn          = 1'b0;
    ps2_key_data    = 8'h00;
    ps2_key_pressed = 1'b0;
    clear           = 1'b0;
    out_ready       = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_ascii", 32'(out_ascii), 32'h00);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'h0);
    resetn = 1'b1;

    // Make/break of 'a' with consumer always ready
    out_ready = 1'b1;
    send(8'h1C);
    check("a_valid", 32'(out_valid), 32'h1);
    check("a_ascii", 32'(out_ascii), 32'h61);
    check("a_count", 32'(count), 32'd1);
    send(8'hF0);
    check("a_popped_valid", 32'(out_valid), 32'h0);
    check("a_popped_count", 32'(count), 32'd0);
    send(8'h1C);
    check("a_break_valid", 32'(out_valid), 32'h0);
    check("a_break_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Shifted B, then shift release, then plain b
    send(8'h12); send(8'h32); send(8'hF0); send(8'h32);
    send(8'hF0); send(8'h12); send(8'h32);
    check("shift_count", 32'(count), 32'd2);
    check("shift_head0", 32'(out_ascii), 32'h42);
    pop_one();
    check("shift_head1", 32'(out_ascii), 32'h62);
    pop_one();
    check("shift_empty", 32'(out_valid), 32'h0);

    // Digits ignore shift; enter and backspace
    send(8'h59); send(8'h16); send(8'hF0); send(8'h59);
    send(8'h5A); send(8'h66);
    check("misc_count", 32'(count), 32'd3);
    check("digit_shift", 32'(out_ascii), 32'h31);
    pop_one();
    check("enter", 32'(out_ascii), 32'h0D);
    pop_one();
    check("bksp", 32'(out_ascii), 32'h08);
    pop_one();

    // Extended prefixes drop their followers
    send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C);
    check("ext_none", 32'(count), 32'd0);
    send(8'h45);
    check("ext_count", 32'(count), 32'd1);
    check("ext_zero", 32'(out_ascii), 32'h30);
    send(8'h1C);
    check("ext_idle", 32'(count), 32'd2);

    // Clear flushes; a strobe in the clear cycle is discarded
    do_clear();
    check("clr_count", 32'(count), 32'd0);
    check("clr_valid", 32'(out_valid), 32'h0);
    send(8'h29);
    @(negedge clock);
    clear           = 1'b1;
    ps2_key_data    = 8'h29;
    ps2_key_pressed = 1'b1;
    @(negedge clock);
    clear           = 1'b0;
    ps2_key_pressed = 1'b0;
    check("clr_strobe_count", 32'(count), 32'd0);
    @(negedge clock);
    check("clr_strobe_late", 32'(count), 32'd0);

    // Fill: 'b' then 15 spaces
    send(8'h32);
    for (int i = 0; i < 15; i++) send(8'h29);
    check("full_count", 32'(count), 32'd16);
    check("full_ovf", 32'(overflow), 32'h0);
    check("full_head", 32'(out_ascii), 32'h62);
    // Push and pop together while full
    @(negedge clock);
    ps2_key_data    = 8'h1C;
    ps2_key_pressed = 1'b1;
    out_ready       = 1'b1;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    out_ready       = 1'b0;
    check("pp_count", 32'(count), 32'd16);
    check("pp_ovf", 32'(overflow), 32'h0);
    check("pp_head", 32'(out_ascii), 32'h20);
    // Push into a full FIFO with no pop
    send(8'h29);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_set", 32'(overflow), 32'h1);
    // Drain: 15 spaces then the 'a' that entered on the push/pop cycle
    @(negedge clock);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain", 32'(out_ascii), (i == 15) ? 32'h61 : 32'h20);
      @(negedge clock);
    end
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'h0);
    check("drain_ascii", 32'(out_ascii), 32'h00);
    check("drain_ovf", 32'(overflow), 32'h1);
    do_clear();
    check("ovf_cleared", 32'(overflow), 32'h0);

    // Reset between a break prefix and its follower
    send(8'h29);
    send(8'hF0);
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_ascii", 32'(out_ascii), 32'h00);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'h0);
    resetn = 1'b1;
    send(8'h1C);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_ascii", 32'(out_ascii), 32'h61);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
